alu_ex_stage: RTL and testbench

Execute-stage front end that drives the core's combinational ALU and consumes its result. It decodes ALUOp/Funct3/Funct7 into the 4-bit ALU Operation code and selects SrcA/SrcB. It resolves branches from the ALU compare result and holds everything in a one-entry EX/MEM output register with a valid/ready handshake, flush, and an accepted-op counter. The ALU itself is instantiated outside this block and connected through the SrcA/SrcB/Operation/ALUResult ports.

---
 rtl/alu_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_alu_ex_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - execute-stage ALU control decode, branch resolve and EX/MEM output register
//
// Purpose: decodes ALUOp/Funct3/Funct7 into the ALU Operation code, steers SrcA/SrcB
// to an external combinational ALU, and captures its result, the branch decision,
// the branch target and an illegal-op flag in a one-entry valid/ready output stage.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready        ID/EX handshake (in_ready = !out_valid || out_ready)
//   ALUOp, Funct3, Funct7      instruction decode fields
//   ALUSrc, Branch             operand-B select, conditional-branch flag
//   RegA, RegB, Imm, PC        operands, immediate and instruction PC
//   SrcA, SrcB, Operation      combinational drive to the external ALU
//   ALUResult                  combinational result from the external ALU
//   flush                      discards the held entry and any same-cycle accept
//   out_valid / out_ready      EX/MEM handshake
//   Result, BrTaken, BrTarget, Illegal  registered entry contents
//   OpCount                    wrapping count of accepted entries

module alu_ex_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     ALUSrc,
    input  logic                     Branch,
    input  logic [DATA_WIDTH-1:0]    RegA,
    input  logic [DATA_WIDTH-1:0]    RegB,
    input  logic [DATA_WIDTH-1:0]    Imm,
    input  logic [DATA_WIDTH-1:0]    PC,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    ALUResult,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    Result,
    output logic                     BrTaken,
    output logic [DATA_WIDTH-1:0]    BrTarget,
    output logic                     Illegal,
    output logic [CNT_WIDTH-1:0]     OpCount
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

    // Only Funct7[5] distinguishes SUB/SRA; the remaining bits are don't-care.
    logic unused_funct7;
    assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

    logic [OPCODE_LENGTH-1:0] operation;
    logic                     op_illegal;
    logic                     cmp_invert;
    logic                     accept;

    logic                     out_valid_d, out_valid_q;
    logic [DATA_WIDTH-1:0]    result_d,    result_q;
    logic                     br_taken_d,  br_taken_q;
    logic [DATA_WIDTH-1:0]    br_target_d, br_target_q;
    logic                     illegal_d,   illegal_q;
    logic [CNT_WIDTH-1:0]     op_count_d,  op_count_q;

    // Control decode. BNE/BGE reuse EQ/SLT and flip the decision afterwards.
    always_comb begin
        operation  = OP_ADD;
        op_illegal = 1'b0;
        cmp_invert = 1'b0;
        unique case (ALUOp)
            2'b00: operation = OP_ADD;
            2'b01: begin
                unique case (Funct3)
                    3'b000: operation = OP_EQ;
                    3'b001: begin operation = OP_EQ;  cmp_invert = 1'b1; end
                    3'b100: operation = OP_SLT;
                    3'b101: begin operation = OP_SLT; cmp_invert = 1'b1; end
                    default: begin operation = OP_ILL; op_illegal = 1'b1; end
                endcase
            end
            default: begin
                unique case (Funct3)
                    // I-type has no SUB: Funct7 there is part of the immediate.
                    3'b000: operation = (ALUOp == 2'b10 && Funct7[5]) ? OP_SUB : OP_ADD;
                    3'b001: operation = OP_SLL;
                    3'b010: operation = OP_SLT;
                    3'b011: begin operation = OP_ILL; op_illegal = 1'b1; end
                    3'b100: operation = OP_XOR;
                    3'b101: operation = Funct7[5] ? OP_SRA : OP_SRL;
                    3'b110: operation = OP_OR;
                    default: operation = OP_AND;
                endcase
            end
        endcase
    end

    assign Operation = operation;
    assign SrcA      = RegA;
    // Branches always compare rs1 against rs2; the immediate only feeds the target.
    assign SrcB      = (ALUOp != 2'b01 && ALUSrc) ? Imm : RegB;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        illegal_d   = illegal_q;
        op_count_d  = op_count_q + CNT_WIDTH'(accept);

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            result_d    = ALUResult;
            br_taken_d  = Branch && !op_illegal && (ALUResult[0] ^ cmp_invert);
            br_target_d = PC + Imm;
            illegal_d   = op_illegal;
        end else if (out_ready) begin
            // Entry drained; data registers keep their last contents.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            illegal_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            illegal_q   <= illegal_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign BrTaken   = br_taken_q;
    assign BrTarget  = br_target_q;
    assign Illegal   = illegal_q;
    assign OpCount   = op_count_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb/tb_alu_ex_stage.sv - self-checking bench for alu_ex_stage
module tb_alu_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_ready4;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic        ALUSrc, Branch;
    logic [31:0] RegA, RegB, Imm, PC;
    logic [31:0] SrcA, SrcB, SrcA4, SrcB4;
    logic [3:0]  Operation, Operation4;
    logic [31:0] ALUResult;
    logic        flush;
    logic        out_valid, out_valid4, out_ready;
    logic [31:0] Result, Result4, BrTarget, BrTarget4;
    logic        BrTaken, BrTaken4, Illegal, Illegal4;
    logic [31:0] OpCount;
    logic [3:0]  OpCount4;

    int checks = 0;
    int errors = 0;
    int cnt    = 0;

    always #5 clk = ~clk;

    alu_ex_stage u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7), .ALUSrc(ALUSrc), .Branch(Branch),
        .RegA(RegA), .RegB(RegB), .Imm(Imm), .PC(PC),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ALUResult(ALUResult),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .BrTaken(BrTaken), .BrTarget(BrTarget), .Illegal(Illegal),
        .OpCount(OpCount)
    );

    // Narrow-counter instance sharing all inputs, used to reach the wrap point quickly.
    alu_ex_stage #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7), .ALUSrc(ALUSrc), .Branch(Branch),
        .RegA(RegA), .RegB(RegB), .Imm(Imm), .PC(PC),
        .SrcA(SrcA4), .SrcB(SrcB4), .Operation(Operation4), .ALUResult(ALUResult),
        .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
        .Result(Result4), .BrTaken(BrTaken4), .BrTarget(BrTarget4), .Illegal(Illegal4),
        .OpCount(OpCount4)
    );

    // External ALU attached to the main instance.
    always_comb begin
        case (Operation)
            4'b0000: ALUResult = SrcA & SrcB;
            4'b0001: ALUResult = SrcA | SrcB;
            4'b0010: ALUResult = SrcA + SrcB;
            4'b0011: ALUResult = SrcA ^ SrcB;
            4'b0100: ALUResult = SrcA << SrcB[4:0];
            4'b0101: ALUResult = SrcA >> SrcB[4:0];
            4'b0110: ALUResult = SrcA - SrcB;
            4'b0111: ALUResult = $unsigned($signed(SrcA) >>> SrcB[4:0]);
            4'b1000: ALUResult = {31'd0, SrcA == SrcB};
            4'b1100: ALUResult = {31'd0, $signed(SrcA) < $signed(SrcB)};
            default: ALUResult = 32'd0;
        endcase
    end

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        alusrc;
        logic        branch;
        logic [31:0] a, b, imm, pc;
        logic [3:0]  exp_op;
        logic [31:0] exp_res;
        logic        exp_taken;
        logic        exp_ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Instruction-level reference: what the instruction means, not how the block decodes it.
    function automatic vec_t ref_model(input vec_t v);
        vec_t        r = v;
        logic [31:0] opb = (v.aluop != 2'b01 && v.alusrc) ? v.imm : v.b;
        logic        eq  = (v.a == v.b);
        logic        lt  = ($signed(v.a) < $signed(v.b));
        logic        cond;
        r.exp_ill = 1'b0;
        r.exp_res = 32'd0;
        cond      = 1'b0;
        if (v.aluop == 2'b00) begin
            r.exp_op = 4'h2; r.exp_res = v.a + opb;  cond = r.exp_res[0];
        end else if (v.aluop == 2'b01) begin
            case (v.f3)
                3'd0: begin r.exp_op = 4'h8; r.exp_res = {31'd0, eq}; cond = eq;  end
                3'd1: begin r.exp_op = 4'h8; r.exp_res = {31'd0, eq}; cond = !eq; end
                3'd4: begin r.exp_op = 4'hC; r.exp_res = {31'd0, lt}; cond = lt;  end
                3'd5: begin r.exp_op = 4'hC; r.exp_res = {31'd0, lt}; cond = !lt; end
                default: begin r.exp_op = 4'hF; r.exp_ill = 1'b1; end
            endcase
        end else begin
            case (v.f3)
                3'd0: if (v.aluop == 2'b10 && v.f7[5]) begin r.exp_op = 4'h6; r.exp_res = v.a - opb; end
                      else begin r.exp_op = 4'h2; r.exp_res = v.a + opb; end
                3'd1: begin r.exp_op = 4'h4; r.exp_res = v.a << opb[4:0]; end
                3'd2: begin r.exp_op = 4'hC; r.exp_res = {31'd0, $signed(v.a) < $signed(opb)}; end
                3'd3: begin r.exp_op = 4'hF; r.exp_ill = 1'b1; end
                3'd4: begin r.exp_op = 4'h3; r.exp_res = v.a ^ opb; end
                3'd5: if (v.f7[5]) begin r.exp_op = 4'h7; r.exp_res = $unsigned($signed(v.a) >>> opb[4:0]); end
                      else begin r.exp_op = 4'h5; r.exp_res = v.a >> opb[4:0]; end
                3'd6: begin r.exp_op = 4'h1; r.exp_res = v.a | opb; end
                default: begin r.exp_op = 4'h0; r.exp_res = v.a & opb; end
            endcase
            cond = r.exp_res[0];
        end
        r.exp_taken = v.branch && !r.exp_ill && cond;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        ALUOp = v.aluop; Funct3 = v.f3; Funct7 = v.f7; ALUSrc = v.alusrc; Branch = v.branch;
        RegA = v.a; RegB = v.b; Imm = v.imm; PC = v.pc;
    endtask

    // Called at posedge+1; leaves at posedge+1 with in_valid low.
    task automatic run_vec(input vec_t v, input string tag);
        drive(v);
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        #1;
        chk({tag, ".op"}, {28'd0, Operation}, {28'd0, v.exp_op});
        @(posedge clk); cnt++; #1;
        in_valid = 1'b0;
        chk({tag, ".valid"},  {31'd0, out_valid}, 32'd1);
        chk({tag, ".result"}, Result, v.exp_res);
        chk({tag, ".taken"},  {31'd0, BrTaken}, {31'd0, v.exp_taken});
        chk({tag, ".target"}, BrTarget, v.pc + v.imm);
        chk({tag, ".illegal"},{31'd0, Illegal}, {31'd0, v.exp_ill});
        chk({tag, ".count"},  OpCount, cnt);
    endtask

    function automatic vec_t mk(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                                input logic alusrc, input logic branch, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                                input logic [3:0] op, input logic [31:0] res, input logic tk,
                                input logic il);
        vec_t v;
        v.aluop = aluop; v.f3 = f3; v.f7 = f7; v.alusrc = alusrc; v.branch = branch;
        v.a = a; v.b = b; v.imm = imm; v.pc = pc;
        v.exp_op = op; v.exp_res = res; v.exp_taken = tk; v.exp_ill = il;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cnt = 0;
        @(posedge clk); #1;
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        drive(mk(2'b00, 3'd0, 7'd0, 1'b0, 1'b0, 0, 0, 0, 0, 4'h2, 0, 1'b0, 1'b0));

        tbl.push_back(mk(2'b10, 3'd0, 7'h20, 0, 0, 10, 3, 0, 0, 4'h6, 7, 0, 0));
        tbl.push_back(mk(2'b01, 3'd1, 7'h00, 0, 1, 5, 5, 32'h20, 32'h100, 4'h8, 1, 0, 0));
        tbl.push_back(mk(2'b01, 3'd1, 7'h00, 0, 1, 5, 6, 32'h20, 32'h100, 4'h8, 0, 1, 0));
        tbl.push_back(mk(2'b10, 3'd3, 7'h00, 0, 0, 9, 4, 0, 0, 4'hF, 0, 0, 1));
        tbl.push_back(mk(2'b01, 3'd2, 7'h00, 0, 1, 3, 3, 8, 32'h40, 4'hF, 0, 0, 1));
        tbl.push_back(mk(2'b11, 3'd0, 7'h20, 1, 0, 10, 99, 3, 0, 4'h2, 13, 0, 0));
        tbl.push_back(mk(2'b00, 3'd2, 7'h00, 1, 0, 32'h1000, 5, 32'hFFFF_FFFC, 0, 4'h2, 32'hFFC, 0, 0));
        tbl.push_back(mk(2'b01, 3'd4, 7'h00, 0, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF0, 32'h10, 4'hC, 1, 1, 0));
        tbl.push_back(mk(2'b01, 3'd5, 7'h00, 0, 1, 32'hFFFF_FFFF, 1, 4, 32'hFFFF_FFFE, 4'hC, 1, 0, 0));
        tbl.push_back(mk(2'b10, 3'd5, 7'h20, 0, 0, 32'h8000_0000, 4, 0, 0, 4'h7, 32'hF800_0000, 0, 0));
        tbl.push_back(mk(2'b10, 3'd5, 7'h00, 0, 0, 32'h8000_0000, 4, 0, 0, 4'h5, 32'h0800_0000, 0, 0));
        tbl.push_back(mk(2'b01, 3'd0, 7'h00, 1, 1, 7, 7, 99, 32'h200, 4'h8, 1, 1, 0));

        // Reset state
        #2;
        chk("rst.valid",   {31'd0, out_valid}, 0);
        chk("rst.ready",   {31'd0, in_ready}, 1);
        chk("rst.result",  Result, 0);
        chk("rst.target",  BrTarget, 0);
        chk("rst.count",   OpCount, 0);
        do_reset();
        chk("idle.valid",  {31'd0, out_valid}, 0);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 200; i++) begin
            rv.aluop  = 2'($urandom_range(0, 3));
            rv.f3     = 3'($urandom_range(0, 7));
            rv.f7     = 7'($urandom);
            rv.alusrc = 1'($urandom);
            rv.branch = (rv.aluop == 2'b01) ? 1'b1 : 1'($urandom_range(0, 7) == 0);
            rv.a      = $urandom;
            rv.b      = ($urandom_range(0, 3) == 0) ? rv.a : $urandom;
            if ($urandom_range(0, 3) == 0) rv.b = 32'($urandom_range(0, 40));
            rv.imm    = $urandom;
            rv.pc     = $urandom;
            rv = ref_model(rv);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // Back-pressure: second op must wait until the first drains.
        do_reset();
        out_ready = 1'b0;
        drive(ref_model(mk(2'b00, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0)));
        in_valid = 1'b1;
        #1; chk("bp.ready0", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        drive(ref_model(mk(2'b00, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 2; k++) begin
            chk("bp.ready_low", {31'd0, in_ready}, 0);
            chk("bp.hold_res",  Result, 3);
            chk("bp.hold_vld",  {31'd0, out_valid}, 1);
            @(posedge clk); #1;
        end
        chk("bp.count1", OpCount, 1);
        out_ready = 1'b1;
        #1; chk("bp.ready_up", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.second",  Result, 10);
        chk("bp.vld2",    {31'd0, out_valid}, 1);
        chk("bp.count2",  OpCount, 2);
        @(posedge clk); #1;
        chk("bp.drained", {31'd0, out_valid}, 0);
        chk("bp.keep",    Result, 10);

        // Flush with a same-cycle handshake: entry dropped, counter still advances.
        drive(ref_model(mk(2'b00, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0, 0, 0)));
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(ref_model(mk(2'b00, 0, 0, 0, 0, 40, 1, 0, 0, 0, 0, 0, 0)));
        flush = 1'b1;
        #1; chk("fl.ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl.valid",  {31'd0, out_valid}, 0);
        chk("fl.keep",   Result, 21);
        chk("fl.count",  OpCount, 4);

        // Asynchronous reset during a hold.
        out_ready = 1'b0;
        drive(ref_model(mk(2'b01, 3'd0, 0, 0, 1, 4, 4, 8, 32'h30, 0, 0, 0, 0)));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ar.pre_taken", {31'd0, BrTaken}, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar.valid",   {31'd0, out_valid}, 0);
        chk("ar.result",  Result, 0);
        chk("ar.taken",   {31'd0, BrTaken}, 0);
        chk("ar.target",  BrTarget, 0);
        chk("ar.illegal", {31'd0, Illegal}, 0);
        chk("ar.count",   OpCount, 0);
        chk("ar.ready",   {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        reset = 1'b0; cnt = 0;
        @(posedge clk); #1;

        // Counter wrap on the 4-bit instance.
        out_ready = 1'b1;
        drive(ref_model(mk(2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)));
        in_valid = 1'b1;
        for (int k = 0; k < 15; k++) @(posedge clk);
        #1;
        chk("wr.c4_15",  {28'd0, OpCount4}, 15);
        chk("wr.c32_15", OpCount, 15);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("wr.c4_wrap", {28'd0, OpCount4}, 0);
        chk("wr.c32_16",  OpCount, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
